// File: rtl/sblk_pkg.sv
// Shared sizing, types and small helpers for the activation arbiter.
// Pure declarations: no logic, no latency, no flow control.
package sblk_pkg;

    localparam int N_SBLK    = 4;
    localparam int WID_ACT   = 8;
    localparam int WID_BURST = 9;
    localparam int WID_SEL   = $clog2(N_SBLK);

    typedef logic [WID_SEL-1:0]   sel_t;
    typedef logic [WID_BURST-1:0] len_t;
    typedef logic [2*WID_ACT-1:0] beat_t;

    typedef enum logic {S_IDLE, S_XFER} arb_state_e;

    function automatic sel_t sel_inc(input sel_t s);
        return (int'(s) == N_SBLK - 1) ? '0 : s + sel_t'(1);
    endfunction

    function automatic logic [N_SBLK-1:0] sel_onehot(input sel_t s);
        logic [N_SBLK-1:0] r;
        r    = '0;
        r[s] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/sblk_act_arb_if.sv
// Config, request, upstream beat and downstream strobe signals of the arbiter.
// slave = arbiter side, master = feeder/controller/config side.
interface sblk_act_arb_if;
    import sblk_pkg::*;

    logic              cfg_wr_en;
    sel_t              cfg_wr_idx;
    len_t              cfg_wr_len;
    logic [N_SBLK-1:0] act_in_req;
    logic              src_vld;
    beat_t             src_data;
    logic              src_rdy;
    sel_t              src_sel;
    logic [N_SBLK-1:0] act_in_vld;
    beat_t             act_in_data;
    logic              busy;
    logic              err_overrun;
    logic              err_zero_len;

    modport slave (
        input  cfg_wr_en, cfg_wr_idx, cfg_wr_len, act_in_req, src_vld, src_data,
        output src_rdy, src_sel, act_in_vld, act_in_data, busy, err_overrun, err_zero_len
    );

    modport master (
        output cfg_wr_en, cfg_wr_idx, cfg_wr_len, act_in_req, src_vld, src_data,
        input  src_rdy, src_sel, act_in_vld, act_in_data, busy, err_overrun, err_zero_len
    );

endinterface

// File: rtl/sblk_rr_arb.sv
// Round-robin pick: first set request at or after ptr, wrapping mod N_SBLK.
// Purely combinational, no flow control.
module sblk_rr_arb
    import sblk_pkg::*;
(
    input  logic [N_SBLK-1:0] req,
    input  sel_t              ptr,
    output sel_t              gnt_idx,
    output logic              gnt_any
);

    logic [WID_SEL:0] idx_w;

    // Walk from the farthest offset back to ptr so the nearest request wins.
    always_comb begin
        gnt_idx = '0;
        gnt_any = 1'b0;
        idx_w   = '0;
        for (int k = N_SBLK - 1; k >= 0; k--) begin
            idx_w = {1'b0, ptr} + (WID_SEL+1)'(k);
            if (idx_w >= (WID_SEL+1)'(N_SBLK)) begin
                idx_w = idx_w - (WID_SEL+1)'(N_SBLK);
            end
            if (req[idx_w[WID_SEL-1:0]]) begin
                gnt_any = 1'b1;
                gnt_idx = idx_w[WID_SEL-1:0];
            end
        end
    end

endmodule

// File: rtl/sblk_act_arb.sv
// Queues per-controller batch requests and streams each granted burst round-robin.
// Beat latency 1 cycle; upstream throttled by src_rdy only during XFER, downstream never stalls.
module sblk_act_arb
    import sblk_pkg::*;
(
    input  logic           clk_l,
    input  logic           rst,
    sblk_act_arb_if.slave  bus
);

    arb_state_e        state_q, state_d;
    logic [N_SBLK-1:0] pend_q, pend_d;
    len_t              len_q [N_SBLK];
    len_t              len_d [N_SBLK];
    len_t              cnt_q, cnt_d;
    sel_t              sel_q, sel_d;
    sel_t              rr_q, rr_d;
    logic [N_SBLK-1:0] vld_q, vld_d;
    beat_t             data_q, data_d;
    logic              ovr_q, ovr_d;
    logic              zl_q, zl_d;

    sel_t              gnt_idx;
    logic              gnt_any;
    logic [N_SBLK-1:0] clr;

    sblk_rr_arb u_rr (
        .req     (pend_q),
        .ptr     (rr_q),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        rr_d    = rr_q;
        vld_d   = '0;
        data_d  = data_q;
        ovr_d   = ovr_q;
        zl_d    = zl_q;
        clr     = '0;
        for (int i = 0; i < N_SBLK; i++) begin
            len_d[i] = len_q[i];
        end

        case (state_q)
            S_IDLE: begin
                if (gnt_any) begin
                    clr[gnt_idx] = 1'b1;
                    sel_d        = gnt_idx;
                    rr_d         = sel_inc(gnt_idx);
                    if (len_q[gnt_idx] == '0) begin
                        zl_d = 1'b1;
                    end else begin
                        cnt_d   = len_q[gnt_idx];
                        state_d = S_XFER;
                    end
                end
            end
            S_XFER: begin
                if (bus.src_vld) begin
                    vld_d  = sel_onehot(sel_q);
                    data_d = bus.src_data;
                    cnt_d  = cnt_q - len_t'(1);
                    if (cnt_q == len_t'(1)) begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A new request in the same cycle as its grant survives the clear.
        pend_d = (pend_q & ~clr) | bus.act_in_req;
        if (|(bus.act_in_req & pend_q & ~clr)) begin
            ovr_d = 1'b1;
        end

        if (bus.cfg_wr_en && (int'(bus.cfg_wr_idx) < N_SBLK)) begin
            len_d[bus.cfg_wr_idx] = bus.cfg_wr_len;
        end
    end

    always_ff @(posedge clk_l) begin
        if (rst) begin
            state_q <= S_IDLE;
            pend_q  <= '0;
            cnt_q   <= '0;
            sel_q   <= '0;
            rr_q    <= '0;
            vld_q   <= '0;
            data_q  <= '0;
            ovr_q   <= 1'b0;
            zl_q    <= 1'b0;
            for (int i = 0; i < N_SBLK; i++) begin
                len_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            rr_q    <= rr_d;
            vld_q   <= vld_d;
            data_q  <= data_d;
            ovr_q   <= ovr_d;
            zl_q    <= zl_d;
            for (int i = 0; i < N_SBLK; i++) begin
                len_q[i] <= len_d[i];
            end
        end
    end

    assign bus.src_rdy      = (state_q == S_XFER);
    assign bus.busy         = (state_q == S_XFER);
    assign bus.src_sel      = sel_q;
    assign bus.act_in_vld   = vld_q;
    assign bus.act_in_data  = data_q;
    assign bus.err_overrun  = ovr_q;
    assign bus.err_zero_len = zl_q;

endmodule
